// File: rtl/norm_scheduler_if.sv
// norm_scheduler_if
//   Bundles every non-clock, non-reset signal of norm_scheduler: the raw
//   sensor frame handshake, the normalizer start/data/result path, the window
//   buffer write port and the classifier window handshake. Signal names keep
//   their i_/o_ prefixes as seen from the scheduler.
//   Every frame bus is eight 16-bit two's-complement lanes, with channel 0 in
//   bits [15:0]. Normalized lanes carry 8 fractional bits.
//
//   Modports
//     master : environment side (sensor, normalizer, window buffer, classifier)
//     slave  : scheduler side
interface norm_scheduler_if #(
  parameter int WINDOW = 8
);
  localparam int AW = $clog2(WINDOW);

  logic                  i_valid;
  logic                  o_ready;
  logic [7:0][15:0]      i_data;
  logic                  o_norm_start;
  logic [7:0][15:0]      o_norm_data;
  logic [7:0][15:0]      i_norm_result;
  logic                  i_norm_finished;
  logic                  o_wr_en;
  logic [AW-1:0]         o_wr_addr;
  logic [7:0][15:0]      o_wr_data;
  logic                  o_window_valid;
  logic [AW-1:0]         o_window_head;
  logic                  i_window_ack;
  logic [15:0]           o_frame_cnt;
  logic                  o_timeout_err;

  modport master (
    output i_valid, i_data, i_norm_result, i_norm_finished, i_window_ack,
    input  o_ready, o_norm_start, o_norm_data, o_wr_en, o_wr_addr, o_wr_data,
           o_window_valid, o_window_head, o_frame_cnt, o_timeout_err
  );

  modport slave (
    input  i_valid, i_data, i_norm_result, i_norm_finished, i_window_ack,
    output o_ready, o_norm_start, o_norm_data, o_wr_en, o_wr_addr, o_wr_data,
           o_window_valid, o_window_head, o_frame_cnt, o_timeout_err
  );
endinterface

// File: rtl/norm_scheduler.sv
// norm_scheduler
//   Sequences raw sensor frames through an external normalizer and writes the
//   normalized frames into a circular window buffer. Once WINDOW frames have
//   been written the window is presented to a classifier; the window slides,
//   so every later write presents it again until acknowledged.
//   A normalization that does not finish within TIMEOUT cycles is dropped and
//   raises a sticky error flag.
//
//   Ports
//     i_clk    : clock, all state changes on the rising edge
//     i_rst_n  : synchronous reset, active HIGH despite the name
//     bus      : norm_scheduler_if.slave (frame handshake, normalizer path,
//                window buffer write port, classifier handshake, status)
module norm_scheduler #(
  parameter int WINDOW  = 8,   // power of two, 2..64
  parameter int TIMEOUT = 15   // 2..255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  norm_scheduler_if.slave bus
);

  localparam int            AW         = $clog2(WINDOW);
  localparam int            FW         = AW + 1;
  localparam logic [FW-1:0] FILL_FULL  = FW'(WINDOW);
  localparam logic [7:0]    TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE,
    S_HOLD
  } state_t;

  state_t           state;
  logic [7:0][15:0] frame_q;
  logic [7:0][15:0] result_q;
  logic [AW-1:0]    wr_ptr;
  logic [FW-1:0]    fill_cnt;
  logic [FW-1:0]    fill_inc;
  logic [7:0]       timer;
  logic [15:0]      frame_cnt;
  logic             timeout_err;
  logic             norm_start;
  logic             wr_en;
  logic             window_valid;

  // Fill count saturates at WINDOW: once full, every write keeps it full.
  assign fill_inc = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + 1'b1;

  // NOTE: all state lives in this one block and uses non-blocking assignments,
  // so every branch reads the pre-edge values regardless of statement order.
  // NOTE: the reset is sampled on the clock edge (active high); the frame and
  // result registers are reset too so the data outputs read zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state        <= S_IDLE;
      frame_q      <= '0;
      result_q     <= '0;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      timer        <= '0;
      frame_cnt    <= '0;
      timeout_err  <= 1'b0;
      norm_start   <= 1'b0;
      wr_en        <= 1'b0;
      window_valid <= 1'b0;
    end else begin
      // Single-cycle strobes: raised only on the transition into their state.
      norm_start <= 1'b0;
      wr_en      <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // o_ready is high whenever IDLE and out of reset, so i_valid alone
          // completes the handshake here.
          if (bus.i_valid) begin
            frame_q    <= bus.i_data;
            norm_start <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          // Finished is tested first so it wins over an expiring timer.
          if (bus.i_norm_finished) begin
            result_q <= bus.i_norm_result;
            wr_en    <= 1'b1;
            state    <= S_WRITE;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        S_WRITE: begin
          // Pointer width is log2(WINDOW), so the increment wraps by itself.
          wr_ptr    <= wr_ptr + 1'b1;
          fill_cnt  <= fill_inc;
          frame_cnt <= frame_cnt + 16'd1;
          if (fill_inc == FILL_FULL) begin
            window_valid <= 1'b1;
            state        <= S_HOLD;
          end else begin
            state <= S_IDLE;
          end
        end

        S_HOLD: begin
          if (bus.i_window_ack) begin
            window_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready is gated by reset so it stays low in the reset cycle itself.
  assign bus.o_ready        = (state == S_IDLE) && !i_rst_n;
  assign bus.o_norm_start   = norm_start;
  assign bus.o_norm_data    = frame_q;
  assign bus.o_wr_en        = wr_en;
  assign bus.o_wr_addr      = wr_ptr;
  assign bus.o_wr_data      = result_q;
  assign bus.o_window_valid = window_valid;
  // After a write the pointer already names the next slot, i.e. the oldest.
  assign bus.o_window_head  = wr_ptr;
  assign bus.o_frame_cnt    = frame_cnt;
  assign bus.o_timeout_err  = timeout_err;

endmodule

// File: tb/tb_norm_scheduler.sv
// tb_norm_scheduler
//   Self-checking bench for norm_scheduler. The reference model tracks only
//   the number of frames written since reset and the sticky error; expected
//   slot, head, count and window state follow from that with plain arithmetic.
//   Cycle numbering: the handshake edge is c0; cycle cN follows the N-th edge.
module tb_norm_scheduler;
  localparam int WINDOW  = 8;
  localparam int TIMEOUT = 15;
  localparam int AW      = $clog2(WINDOW);

  typedef logic [7:0][15:0] frame_t;

  typedef struct {
    logic   start_seen;  // o_norm_start in c1
    bit     start_extra; // o_norm_start seen again after c1
    bit     ndata_ok;    // o_norm_data equal to the frame from START to WRITE
    int     wr_count;
    int     wr_cycle;
    logic [AW-1:0] addr;
    frame_t wdata;
    int     err_cycle;   // first cycle o_timeout_err observed high
    int     end_cycle;   // first cycle back in IDLE or HOLD
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Reference model state.
  int   exp_writes = 0;
  bit   exp_err    = 1'b0;

  norm_scheduler_if #(.WINDOW(WINDOW)) bus ();

  norm_scheduler #(.WINDOW(WINDOW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic frame_t rand_frame();
    frame_t r;
    for (int c = 0; c < 8; c++) r[c] = 16'($urandom);
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_slot(input int n);
    return AW'(n % WINDOW);
  endfunction

  // Drives one frame and watches the DUT for up to 40 cycles. fin_delay is
  // the number of cycles after START at which finished is pulsed (-1: never).
  task automatic run_frame(input frame_t data, input int fin_delay,
                           input frame_t res, output obs_t o);
    o = '{default: 0};
    o.wr_cycle  = -1;
    o.err_cycle = -1;
    o.end_cycle = -1;
    o.ndata_ok  = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = data;
    @(negedge clk);                       // c1
    bus.i_valid = 1'b0;
    bus.i_data  = rand_frame();
    o.start_seen = bus.o_norm_start;
    if (bus.o_norm_data !== data) o.ndata_ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);                     // c(k+1)
      bus.i_norm_finished = 1'b0;
      if (bus.o_timeout_err === 1'b1 && o.err_cycle < 0 && !exp_err) o.err_cycle = k + 1;
      if (bus.o_ready === 1'b1 || bus.o_window_valid === 1'b1) begin
        o.end_cycle = k + 1;
        break;
      end
      if (bus.o_norm_start !== 1'b0) o.start_extra = 1'b1;
      if (bus.o_norm_data !== data) o.ndata_ok = 1'b0;
      if (bus.o_wr_en === 1'b1) begin
        o.wr_count++;
        o.wr_cycle = k + 1;
        o.addr     = bus.o_wr_addr;
        o.wdata    = bus.o_wr_data;
      end
      bus.i_norm_finished = (k == fin_delay);
      bus.i_norm_result   = (k == fin_delay) ? res : rand_frame();
    end
    bus.i_norm_finished = 1'b0;
  endtask

  task automatic ack_window();
    bus.i_window_ack = 1'b1;
    @(negedge clk);
    bus.i_window_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_during: got %b expected 0", bus.o_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", bus.o_ready); end
    checks++; if ({bus.o_norm_start, bus.o_wr_en, bus.o_window_valid, bus.o_timeout_err} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {bus.o_norm_start, bus.o_wr_en, bus.o_window_valid, bus.o_timeout_err}); end
    checks++; if ({bus.o_frame_cnt, bus.o_wr_addr, bus.o_window_head} !== '0) begin errors++; $display("FAIL reset_counters: cnt=%0d addr=%0d head=%0d expected 0", bus.o_frame_cnt, bus.o_wr_addr, bus.o_window_head); end
    checks++; if ({bus.o_norm_data, bus.o_wr_data} !== '0) begin errors++; $display("FAIL reset_data: norm=%h wr=%h expected 0", bus.o_norm_data, bus.o_wr_data); end
  endtask

  task automatic test_nominal();
    obs_t   o;
    frame_t data = rand_frame();
    frame_t res  = {8{16'h0100}};
    run_frame(data, 3, res, o);
    exp_writes++;
    checks++; if (o.start_seen !== 1'b1 || o.start_extra) begin errors++; $display("FAIL nominal_start: c1=%b extra=%0d expected 1/0", o.start_seen, o.start_extra); end
    checks++; if (o.wr_cycle != 5 || o.wr_count != 1) begin errors++; $display("FAIL nominal_wr_cycle: got c%0d x%0d expected c5 x1", o.wr_cycle, o.wr_count); end
    checks++; if (o.addr !== exp_slot(exp_writes - 1)) begin errors++; $display("FAIL nominal_addr: got %0d expected %0d", o.addr, exp_slot(exp_writes - 1)); end
    checks++; if (o.wdata !== res) begin errors++; $display("FAIL nominal_wdata: got %h expected %h", o.wdata, res); end
    checks++; if (bus.o_frame_cnt !== 16'(exp_writes)) begin errors++; $display("FAIL nominal_cnt: got %0d expected %0d", bus.o_frame_cnt, exp_writes); end
    checks++; if (o.end_cycle != 6 || bus.o_ready !== 1'b1) begin errors++; $display("FAIL nominal_idle: got c%0d ready=%b expected c6 ready=1", o.end_cycle, bus.o_ready); end
    checks++; if (!o.ndata_ok) begin errors++; $display("FAIL nominal_norm_data: got unstable expected %h", data); end
  endtask

  task automatic test_back_to_back();
    obs_t   o;
    frame_t res;
    int     d;
    for (int f = 0; f < WINDOW - 1; f++) begin
      res = rand_frame();
      d   = int'($urandom_range(1, 8));
      run_frame(rand_frame(), d, res, o);
      exp_writes++;
      checks++; if (o.wr_cycle != d + 2 || o.wr_count != 1) begin errors++; $display("FAIL b2b_wr_cycle[%0d]: got c%0d x%0d expected c%0d x1", f, o.wr_cycle, o.wr_count, d + 2); end
      checks++; if (o.addr !== exp_slot(exp_writes - 1) || o.wdata !== res) begin errors++; $display("FAIL b2b_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h", f, o.addr, o.wdata, exp_slot(exp_writes - 1), res); end
      checks++; if (bus.o_frame_cnt !== 16'(exp_writes)) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", f, bus.o_frame_cnt, exp_writes); end
      checks++; if (bus.o_window_valid !== (exp_writes >= WINDOW) || bus.o_ready !== (exp_writes < WINDOW)) begin errors++; $display("FAIL b2b_window[%0d]: got valid=%b ready=%b expected valid=%b", f, bus.o_window_valid, bus.o_ready, exp_writes >= WINDOW); end
    end
    checks++; if (bus.o_window_head !== exp_slot(exp_writes)) begin errors++; $display("FAIL b2b_head: got %0d expected %0d", bus.o_window_head, exp_slot(exp_writes)); end
  endtask

  task automatic test_hold_backpressure();
    bus.i_valid = 1'b1;
    bus.i_data  = rand_frame();
    for (int i = 0; i < 10; i++) begin
      bus.i_norm_finished = i[0];
      @(negedge clk);
      checks++; if ({bus.o_ready, bus.o_window_valid, bus.o_wr_en, bus.o_norm_start} !== 4'b0100) begin errors++; $display("FAIL hold_cycle[%0d]: ready/valid/wr/start got %b expected 0100", i, {bus.o_ready, bus.o_window_valid, bus.o_wr_en, bus.o_norm_start}); end
    end
    bus.i_valid         = 1'b0;
    bus.i_norm_finished = 1'b0;
    ack_window();
    checks++; if (bus.o_window_valid !== 1'b0 || bus.o_ready !== 1'b1) begin errors++; $display("FAIL hold_ack: valid=%b ready=%b expected 0/1", bus.o_window_valid, bus.o_ready); end
    @(negedge clk);
    checks++; if (bus.o_norm_start !== 1'b0 || bus.o_frame_cnt !== 16'(exp_writes)) begin errors++; $display("FAIL hold_no_latch: start=%b cnt=%0d expected 0/%0d", bus.o_norm_start, bus.o_frame_cnt, exp_writes); end
  endtask

  task automatic test_slide();
    obs_t   o;
    frame_t res = rand_frame();
    run_frame(rand_frame(), 2, res, o);
    exp_writes++;
    checks++; if (o.addr !== exp_slot(exp_writes - 1) || o.wdata !== res) begin errors++; $display("FAIL slide_write: got addr=%0d data=%h expected addr=%0d data=%h", o.addr, o.wdata, exp_slot(exp_writes - 1), res); end
    checks++; if (bus.o_window_valid !== 1'b1 || bus.o_window_head !== exp_slot(exp_writes)) begin errors++; $display("FAIL slide_head: valid=%b head=%0d expected 1/%0d", bus.o_window_valid, bus.o_window_head, exp_slot(exp_writes)); end
    ack_window();
  endtask

  task automatic test_stray_finished_idle();
    bit wr_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_norm_finished = 1'b1;
      bus.i_norm_result   = rand_frame();
      @(negedge clk);
      if (bus.o_wr_en !== 1'b0 || bus.o_ready !== 1'b1) wr_seen = 1'b1;
    end
    bus.i_norm_finished = 1'b0;
    @(negedge clk);
    checks++; if (wr_seen || bus.o_frame_cnt !== 16'(exp_writes)) begin errors++; $display("FAIL stray_finished: disturbed=%0d cnt=%0d expected 0/%0d", wr_seen, bus.o_frame_cnt, exp_writes); end
  endtask

  task automatic test_finish_at_limit();
    obs_t   o;
    frame_t res = rand_frame();
    run_frame(rand_frame(), TIMEOUT, res, o);
    exp_writes++;
    checks++; if (o.wr_cycle != TIMEOUT + 2 || o.wdata !== res) begin errors++; $display("FAIL limit_write: got c%0d data=%h expected c%0d data=%h", o.wr_cycle, o.wdata, TIMEOUT + 2, res); end
    checks++; if (bus.o_timeout_err !== 1'b0 || o.err_cycle != -1) begin errors++; $display("FAIL limit_no_err: err=%b at c%0d expected 0", bus.o_timeout_err, o.err_cycle); end
    ack_window();
  endtask

  task automatic test_timeout();
    obs_t o;
    run_frame(rand_frame(), -1, rand_frame(), o);
    exp_err = 1'b1;
    checks++; if (o.err_cycle != TIMEOUT + 2) begin errors++; $display("FAIL timeout_cycle: got c%0d expected c%0d", o.err_cycle, TIMEOUT + 2); end
    checks++; if (o.wr_count != 0 || bus.o_frame_cnt !== 16'(exp_writes)) begin errors++; $display("FAIL timeout_no_write: writes=%0d cnt=%0d expected 0/%0d", o.wr_count, bus.o_frame_cnt, exp_writes); end
    checks++; if (o.end_cycle != TIMEOUT + 2 || bus.o_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got c%0d ready=%b expected c%0d ready=1", o.end_cycle, bus.o_ready, TIMEOUT + 2); end
    @(negedge clk);
    checks++; if (bus.o_timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", bus.o_timeout_err); end
  endtask

  task automatic test_reset_in_hold();
    obs_t o;
    run_frame(rand_frame(), 2, rand_frame(), o);
    exp_writes++;
    checks++; if (bus.o_window_valid !== 1'b1 || bus.o_timeout_err !== exp_err) begin errors++; $display("FAIL rst_hold_pre: valid=%b err=%b expected 1/%b", bus.o_window_valid, bus.o_timeout_err, exp_err); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_writes = 0;
    exp_err    = 1'b0;
    checks++; if ({bus.o_ready, bus.o_window_valid, bus.o_wr_en, bus.o_norm_start} !== 4'b0000) begin errors++; $display("FAIL rst_hold_during: ready/valid/wr/start got %b expected 0000", {bus.o_ready, bus.o_window_valid, bus.o_wr_en, bus.o_norm_start}); end
    @(negedge clk);
    checks++; if (bus.o_ready !== 1'b1 || bus.o_timeout_err !== 1'b0 || bus.o_window_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_after: ready=%b err=%b valid=%b expected 1/0/0", bus.o_ready, bus.o_timeout_err, bus.o_window_valid); end
    checks++; if ({bus.o_frame_cnt, bus.o_window_head} !== '0) begin errors++; $display("FAIL rst_hold_counters: cnt=%0d head=%0d expected 0/0", bus.o_frame_cnt, bus.o_window_head); end
  endtask

  task automatic test_reset_in_wait();
    obs_t   o;
    frame_t res = rand_frame();
    bit     wr_seen = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = rand_frame();
    @(negedge clk);                       // c1 START
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);            // c3 WAIT
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.o_ready, bus.o_norm_start, bus.o_wr_en} !== 3'b000 || bus.o_norm_data !== '0) begin errors++; $display("FAIL rst_wait_during: ready/start/wr=%b data=%h expected 000/0", {bus.o_ready, bus.o_norm_start, bus.o_wr_en}, bus.o_norm_data); end
    rst = 1'b0;
    bus.i_norm_finished = 1'b1;
    bus.i_norm_result   = rand_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_norm_finished = 1'b0;
      if (bus.o_wr_en !== 1'b0 || bus.o_ready !== 1'b1) wr_seen = 1'b1;
    end
    checks++; if (wr_seen || bus.o_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_wait_late_finish: disturbed=%0d cnt=%0d expected 0/0", wr_seen, bus.o_frame_cnt); end
    run_frame(rand_frame(), 3, res, o);
    exp_writes++;
    checks++; if (o.wr_cycle != 5 || o.addr !== exp_slot(0) || bus.o_frame_cnt !== 16'(exp_writes)) begin errors++; $display("FAIL rst_wait_restart: got c%0d addr=%0d cnt=%0d expected c5 addr=0 cnt=1", o.wr_cycle, o.addr, bus.o_frame_cnt); end
  endtask

  initial begin
    bus.i_valid         = 1'b0;
    bus.i_data          = '0;
    bus.i_norm_result   = '0;
    bus.i_norm_finished = 1'b0;
    bus.i_window_ack    = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_hold_backpressure();
    test_slide();
    test_stray_finished_idle();
    test_finish_at_limit();
    test_timeout();
    test_reset_in_hold();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/norm_scheduler.md
NORM_SCHEDULER -- requirements
Module: norm_scheduler

Interface
REQ-001 Parameter: WINDOW, 8, number of normalized frames per classification window; power of two, 2..64.
REQ-002 Parameter: TIMEOUT, 15, maximum cycles spent waiting for normalizer completion; 2..255.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-high despite the name: high at a rising edge resets the block.
REQ-005 i_valid  input  1  raw sensor frame available on i_data.
REQ-006 o_ready  output  1  block can accept a frame; transfer occurs on an edge where i_valid and o_ready are both high.
REQ-007 i_data  input  8 x 16 signed  raw integer sensor channels 0..7.
REQ-008 o_norm_start  output  1  single-cycle start pulse to the normalizer.
REQ-009 o_norm_data  output  8 x 16 signed  latched raw frame driven to the normalizer data inputs.
REQ-010 i_norm_result  input  8 x 16 signed  normalizer fixed-point output, 8 fractional bits.
REQ-011 i_norm_finished  input  1  normalizer completion pulse.
REQ-012 o_wr_en  output  1  write strobe into the window buffer.
REQ-013 o_wr_addr  output  log2(WINDOW)  window buffer slot being written.
REQ-014 o_wr_data  output  8 x 16 signed  normalized frame being written.
REQ-015 o_window_valid  output  1  window full and ready for the classifier.
REQ-016 o_window_head  output  log2(WINDOW)  slot holding the oldest frame of the presented window.
REQ-017 i_window_ack  input  1  classifier has consumed the window.
REQ-018 o_frame_cnt  output  16  count of frames written, wraps at 65535 -> 0.
REQ-019 o_timeout_err  output  1  sticky flag: a normalization timed out.

Function
REQ-020 FSM states: IDLE, START, WAIT, WRITE, HOLD; exactly one active.
REQ-021 IDLE: o_ready = 1; on handshake latch i_data into the frame register -> START.
REQ-022 START: o_norm_start = 1 for exactly this cycle, wait timer cleared -> WAIT.
REQ-023 o_norm_data SHALL equal the frame register, held stable from START through WRITE; the normalizer samples it the cycle after start.
REQ-024 WAIT: timer increments each cycle; i_norm_finished high -> capture i_norm_result -> WRITE.
REQ-025 WAIT: TIMEOUT cycles elapse without finished -> set o_timeout_err, discard frame, no write, no count change -> IDLE.
REQ-026 Finished on the same cycle the timer expires: finished wins, no error.
REQ-027 i_norm_finished outside WAIT SHALL be ignored.
REQ-028 WRITE: o_wr_en = 1 for one cycle, o_wr_addr = write pointer, o_wr_data = captured result; pointer increments modulo WINDOW; fill count increments, saturating at WINDOW; o_frame_cnt increments.
REQ-029 After WRITE: fill count equals WINDOW -> HOLD, else -> IDLE.
REQ-030 HOLD: o_window_valid = 1, o_window_head = write pointer (oldest slot), o_ready = 0; i_window_ack -> IDLE next cycle; the window slides, so every subsequent write re-enters HOLD.
REQ-031 Nominal latency, normalizer finishing 3 cycles after start: handshake edge c0; START c1; WAIT c2-c4; finished in c4; WRITE c5; IDLE or HOLD c6.
REQ-032 o_ready SHALL be 0 in all states except IDLE; i_valid without o_ready has no effect.
REQ-033 o_norm_start, o_wr_en and o_window_valid SHALL be registered outputs.

Reset
REQ-034 Reset values: state IDLE, all outputs 0 except o_ready; frame/result registers 0; pointer, fill count, timer, o_frame_cnt 0; o_timeout_err 0.
REQ-035 o_ready SHALL be 0 during the reset cycle and 1 from the first cycle after reset release.
REQ-036 Reset mid-operation (any state) SHALL abandon the frame, drop any pending window, clear the sticky error, and suppress any write or start pulse from that cycle onward.

Verification
REQ-037 Single frame, 3-cycle normalizer model returning 0x0100 on all channels -> o_norm_start at c1, o_wr_en at c5, o_wr_addr 0, o_wr_data all 0x0100, o_frame_cnt 1.
REQ-038 WINDOW=8, 8 back-to-back frames -> o_window_valid after 8th write with o_window_head 0; ack; 9th frame writes slot 0, HOLD again with o_window_head 1.
REQ-039 Normalizer never finishes -> o_timeout_err 1 exactly TIMEOUT=15 cycles after WAIT entry, no o_wr_en, o_ready 1 next cycle, o_frame_cnt unchanged.
REQ-040 Finished asserted on the 15th WAIT cycle -> write occurs, o_timeout_err stays 0.
REQ-041 i_valid held high during HOLD for 10 cycles -> o_ready 0, no frame latched until ack; stray i_norm_finished in IDLE -> no write.
REQ-042 Reset asserted in WAIT and in HOLD -> next cycle all outputs at reset values; finished arriving after reset -> no write.
